// File: rtl/rv32_pipe_pkg.sv
//------------------------------------------------------------------------------
// Module   : rv32_pipe_pkg
// Desc     : Shared forwarding codes, widths and stage record for the RV32I pipe
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv32_pipe_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int RADDR_DEF = 5;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_S1 = 2'b01;
   localparam logic [1:0] FWD_S2 = 2'b10;

   typedef struct packed {
      logic                 valid;
      logic [RADDR_DEF-1:0] rd;
      logic [XLEN_DEF-1:0]  data;
      logic                 is_load;
      logic                 ready;
   } stage_t;

   localparam stage_t STAGE_BUBBLE = '0;

   typedef enum logic [0:0] {
      ST_RUN       = 1'b0,
      ST_LOAD_WAIT = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/fwd_operand_mux.sv
//------------------------------------------------------------------------------
// Module   : fwd_operand_mux
// Desc     : Selects one operand from register file, S1 or S2 result
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fwd_operand_mux
   import rv32_pipe_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [1:0]      sel,
   input  logic [XLEN-1:0] rf_data,
   input  logic [XLEN-1:0] s1_data,
   input  logic [XLEN-1:0] s2_data,
   output logic [XLEN-1:0] op_out
);

   // Code 11 falls through to S1: the newest result wins.
   always_comb begin
      op_out = s1_data;
      case (sel)
         FWD_RF:  op_out = rf_data;
         FWD_S2:  op_out = s2_data;
         default: op_out = s1_data;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/wb_forward_pipe.sv
//------------------------------------------------------------------------------
// Module   : wb_forward_pipe
// Desc     : MEM/WB stages, load-data capture with stall, RF write, forwarding
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_forward_pipe
   import rv32_pipe_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int RADDR = RADDR_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic [RADDR-1:0] ex_rd,
   input  logic [XLEN-1:0]  ex_result,
   input  logic             ex_is_load,
   input  logic             ex_no_wb,
   input  logic             flush,
   input  logic             mem_rvalid,
   input  logic [XLEN-1:0]  mem_rdata,
   input  logic [1:0]       fwd_sel1,
   input  logic [1:0]       fwd_sel2,
   input  logic [XLEN-1:0]  rf_rdata1,
   input  logic [XLEN-1:0]  rf_rdata2,
   output logic [XLEN-1:0]  op1_out,
   output logic [XLEN-1:0]  op2_out,
   output logic             rf_we,
   output logic [RADDR-1:0] rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   output logic             stall_out
);

   state_t r_state;
   state_t w_state_nx;
   stage_t r_s1;
   stage_t r_s2;
   logic   r_drop_pending;

   logic   w_s1_pending;
   logic   w_capture;
   logic   w_hold;
   logic   w_new_valid;
   logic   w_unused_s2;

   assign w_s1_pending = r_s1.valid & r_s1.is_load & ~r_s1.ready;
   assign w_capture    = mem_rvalid & w_s1_pending & ~r_drop_pending;
   // S1 must hold from the first cycle a load sits unready, before the stall shows.
   assign w_hold       = (r_state == ST_LOAD_WAIT) | w_s1_pending;
   assign w_new_valid  = ex_valid & ~ex_no_wb & ~flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_s1_pending & ~w_capture & ~flush) begin
               w_state_nx = ST_LOAD_WAIT;
            end
         end
         ST_LOAD_WAIT: begin
            if (flush | w_capture | ~w_s1_pending) begin
               w_state_nx = ST_RUN;
            end
         end
         default: w_state_nx = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1           <= STAGE_BUBBLE;
         r_s2           <= STAGE_BUBBLE;
         r_drop_pending <= 1'b0;
      end else begin
         if (mem_rvalid & r_drop_pending) begin
            r_drop_pending <= 1'b0;
         end
         if (w_hold) begin
            r_s2 <= STAGE_BUBBLE;
            if (flush) begin
               r_s1 <= STAGE_BUBBLE;
               // A response arriving with the flush is the one being abandoned.
               if (w_s1_pending) begin
                  r_drop_pending <= r_drop_pending | ~mem_rvalid;
               end
            end else if (w_capture) begin
               r_s1.data  <= mem_rdata;
               r_s1.ready <= 1'b1;
            end
         end else begin
            r_s2         <= r_s1;
            r_s1.valid   <= w_new_valid;
            r_s1.rd      <= w_new_valid ? ex_rd : '0;
            r_s1.data    <= ex_result;
            r_s1.is_load <= ex_is_load;
            r_s1.ready   <= ~ex_is_load;
         end
      end
   end

   assign rf_we       = r_s2.valid & (|r_s2.rd);
   assign rf_waddr    = r_s2.rd;
   assign rf_wdata    = r_s2.data;
   assign stall_out   = (r_state == ST_LOAD_WAIT);
   assign w_unused_s2 = ^{r_s2.is_load, r_s2.ready};

   fwd_operand_mux #(.XLEN(XLEN)) u_fwd_op1 (
      .sel     (fwd_sel1),
      .rf_data (rf_rdata1),
      .s1_data (r_s1.data),
      .s2_data (r_s2.data),
      .op_out  (op1_out)
   );

   fwd_operand_mux #(.XLEN(XLEN)) u_fwd_op2 (
      .sel     (fwd_sel2),
      .rf_data (rf_rdata2),
      .s1_data (r_s1.data),
      .s2_data (r_s2.data),
      .op_out  (op2_out)
   );

endmodule

`default_nettype wire

// File: tb/tb_wb_forward_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_wb_forward_pipe
// Desc     : Directed bench with a register-write scoreboard for wb_forward_pipe
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_forward_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_is_load, ex_no_wb, flush, mem_rvalid;
   logic [4:0]  ex_rd;
   logic [31:0] ex_result, mem_rdata, rf_rdata1, rf_rdata2;
   logic [1:0]  fwd_sel1, fwd_sel2;
   logic [31:0] op1_out, op2_out, rf_wdata;
   logic [4:0]  rf_waddr;
   logic        rf_we, stall_out;

   int          total = 0;
   int          bad   = 0;
   logic [36:0] exp_q[$];

   always #5 clk = ~clk;

   wb_forward_pipe dut (
      .clk        (clk),
      .reset      (reset),
      .ex_valid   (ex_valid),
      .ex_rd      (ex_rd),
      .ex_result  (ex_result),
      .ex_is_load (ex_is_load),
      .ex_no_wb   (ex_no_wb),
      .flush      (flush),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .fwd_sel1   (fwd_sel1),
      .fwd_sel2   (fwd_sel2),
      .rf_rdata1  (rf_rdata1),
      .rf_rdata2  (rf_rdata2),
      .op1_out    (op1_out),
      .op2_out    (op2_out),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .stall_out  (stall_out)
   );

   // Write-port monitor: every write must match the oldest expected write.
   always @(negedge clk) begin
      if (!reset && rf_we) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rf_write: unexpected write x%0d=%h, none expected", rf_waddr, rf_wdata);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            if ({rf_waddr, rf_wdata} !== e) begin
               bad++;
               $display("FAIL rf_write: got x%0d=%h expected x%0d=%h",
                        rf_waddr, rf_wdata, e[36:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [4:0] rd, input logic [31:0] res,
                        input logic is_load, input logic no_wb);
      ex_valid   = 1'b1;
      ex_rd      = rd;
      ex_result  = res;
      ex_is_load = is_load;
      ex_no_wb   = no_wb;
      step();
      ex_valid   = 1'b0;
      ex_is_load = 1'b0;
      ex_no_wb   = 1'b0;
      ex_rd      = '0;
      ex_result  = '0;
   endtask

   task automatic mem_resp(input logic [31:0] d);
      mem_rvalid = 1'b1;
      mem_rdata  = d;
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
   endtask

   initial begin
      reset = 1'b1; ex_valid = 1'b0; ex_rd = '0; ex_result = '0; ex_is_load = 1'b0;
      ex_no_wb = 1'b0; flush = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      fwd_sel1 = 2'b00; fwd_sel2 = 2'b00; rf_rdata1 = '0; rf_rdata2 = '0;
      step(); step();
      check("reset_rf_we", rf_we, 0);
      check("reset_stall", stall_out, 0);
      check("reset_op1", op1_out, 0);
      check("reset_op2", op2_out, 0);
      check("reset_waddr", rf_waddr, 0);
      check("reset_wdata", rf_wdata, 0);
      reset = 1'b0;

      // ALU chain
      exp_q.push_back({5'd5, 32'h11});
      issue(5'd5, 32'h11, 1'b0, 1'b0);
      exp_q.push_back({5'd6, 32'h22});
      issue(5'd6, 32'h22, 1'b0, 1'b0);
      fwd_sel1 = 2'b01; fwd_sel2 = 2'b10; rf_rdata1 = 32'h1234; #1;
      check("chain_sel01", op1_out, 32'h22);
      check("chain_sel10", op2_out, 32'h11);
      fwd_sel1 = 2'b00; #1;
      check("chain_sel00", op1_out, 32'h1234);
      step(); step();

      // Newest wins on code 11
      exp_q.push_back({5'd1, 32'h2});
      issue(5'd1, 32'h2, 1'b0, 1'b0);
      exp_q.push_back({5'd2, 32'h1});
      issue(5'd2, 32'h1, 1'b0, 1'b0);
      fwd_sel1 = 2'b11; fwd_sel2 = 2'b11; #1;
      check("sel11_op1", op1_out, 32'h1);
      check("sel11_op2", op2_out, 32'h1);
      step(); step();

      // x0 and no-writeback
      issue(5'd0, 32'h55, 1'b0, 1'b0);
      issue(5'd3, 32'h0, 1'b0, 1'b1);
      fwd_sel1 = 2'b01; #1;
      check("x0_no_we", rf_we, 0);
      check("nowb_s1_data", op1_out, 32'h0);
      step();
      check("nowb_no_we", rf_we, 0);
      step();

      // Load with a preceding ALU entry
      exp_q.push_back({5'd4, 32'h44});
      issue(5'd4, 32'h44, 1'b0, 1'b0);
      exp_q.push_back({5'd7, 32'hDEADBEEF});
      issue(5'd7, 32'h0, 1'b1, 1'b0);
      check("load_c1_stall", stall_out, 0);
      step();
      check("load_stall1", stall_out, 1);
      step();
      check("load_stall2", stall_out, 1);
      step();
      check("load_stall3", stall_out, 1);
      mem_resp(32'hDEADBEEF);
      check("load_unstall", stall_out, 0);
      step(); step(); step();

      // Flush during load wait, then a fresh load sees the discarded response
      issue(5'd8, 32'h0, 1'b1, 1'b0);
      step();
      check("flush_pre_stall", stall_out, 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_unstall", stall_out, 0);
      exp_q.push_back({5'd9, 32'hBBBB});
      issue(5'd9, 32'h0, 1'b1, 1'b0);
      step();
      mem_resp(32'hAAAA);
      check("drop_still_stall", stall_out, 1);
      mem_resp(32'hBBBB);
      check("drop_unstall", stall_out, 0);
      step(); step(); step();

      // Reset while stalled, then a stray response
      issue(5'd10, 32'h0, 1'b1, 1'b0);
      step();
      check("rst_pre_stall", stall_out, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      fwd_sel1 = 2'b01; fwd_sel2 = 2'b10; #1;
      check("rst_stall", stall_out, 0);
      check("rst_rf_we", rf_we, 0);
      check("rst_op1", op1_out, 0);
      check("rst_op2", op2_out, 0);
      mem_resp(32'h5555);
      step(); step(); step();
      check("stray_no_stall", stall_out, 0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
